// File: rtl/data_loader.sv
// data_loader: unpacks a byte stream into 128-bit global-buffer lines and 330-bit NIT entries.
// Lines are written first, then NIT entries, followed by a one-cycle LOAD_DONE pulse.
module data_loader #(
    parameter int DATA_WIDTH            = 8,
    parameter int length                = 16,
    parameter int global_buf_addr_width = 16,
    parameter int NIT_addr_width        = 12,
    parameter int NIT_point_index       = 10,
    parameter int NIT_neighbor          = 32
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          start,
    input  logic [global_buf_addr_width-1:0]              INIT_LOAD_ADDR,
    input  logic [15:0]                                   GB_LINES,
    input  logic [12:0]                                   NIT_ENTRIES,
    input  logic                                          s_valid,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    output logic                                          s_ready,
    output logic                                          global_buf_write,
    output logic [global_buf_addr_width-1:0]              waddr,
    output logic [DATA_WIDTH*length-1:0]                  GB_data_line,
    output logic                                          NIT_write,
    output logic [NIT_addr_width-1:0]                     NIT_addr,
    output logic [(NIT_neighbor+1)*NIT_point_index-1:0]   NIT_data,
    output logic                                          busy,
    output logic                                          LOAD_DONE
);
    localparam int GW  = DATA_WIDTH * length;
    localparam int NW  = (NIT_neighbor + 1) * NIT_point_index;
    localparam int NB  = 2 * (NIT_neighbor + 1);
    localparam int GBW = $clog2(GW);
    localparam int NBW = $clog2(NW);
    localparam int HI  = NIT_point_index - DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, GB_FILL, GB_WR, NIT_FILL, NIT_WR, FIN} state_t;

    state_t                           state_q, state_d;
    logic [global_buf_addr_width-1:0] base_q, base_d;
    logic [15:0]                      lines_q, lines_d, line_cnt_q, line_cnt_d;
    logic [12:0]                      ents_q, ents_d, ent_cnt_q, ent_cnt_d;
    logic [6:0]                       bcnt_q, bcnt_d;
    logic [GW-1:0]                    gb_q, gb_d;
    logic [NW-1:0]                    nit_q, nit_d;
    logic [GBW-1:0]                   gbit;
    logic [NBW-1:0]                   nbit;
    logic                             acc;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        lines_d    = lines_q;
        ents_d     = ents_q;
        line_cnt_d = line_cnt_q;
        ent_cnt_d  = ent_cnt_q;
        bcnt_d     = bcnt_q;
        gb_d       = gb_q;
        nit_d      = nit_q;
        acc        = s_ready && s_valid;
        gbit       = GBW'(bcnt_q) * GBW'(DATA_WIDTH);
        // Each point index spans two bytes, so byte pair bcnt/2 selects the 10-bit slot.
        nbit       = NBW'(bcnt_q[6:1]) * NBW'(NIT_point_index);
        case (state_q)
            IDLE: if (start) begin
                base_d     = INIT_LOAD_ADDR;
                lines_d    = GB_LINES;
                ents_d     = NIT_ENTRIES;
                line_cnt_d = '0;
                ent_cnt_d  = '0;
                bcnt_d     = '0;
                state_d    = GB_LINES != 0 ? GB_FILL : NIT_ENTRIES != 0 ? NIT_FILL : FIN;
            end
            GB_FILL: if (acc) begin
                gb_d[gbit +: DATA_WIDTH] = s_data;
                bcnt_d  = bcnt_q == 7'(length - 1) ? 7'd0 : bcnt_q + 7'd1;
                state_d = bcnt_q == 7'(length - 1) ? GB_WR : GB_FILL;
            end
            GB_WR: begin
                line_cnt_d = line_cnt_q + 16'd1;
                state_d    = line_cnt_d != lines_q ? GB_FILL : ents_q != 0 ? NIT_FILL : FIN;
            end
            NIT_FILL: if (acc) begin
                if (bcnt_q[0])
                    nit_d[nbit + NBW'(DATA_WIDTH) +: HI] = s_data[HI-1:0];
                else
                    nit_d[nbit +: DATA_WIDTH] = s_data;
                bcnt_d  = bcnt_q == 7'(NB - 1) ? 7'd0 : bcnt_q + 7'd1;
                state_d = bcnt_q == 7'(NB - 1) ? NIT_WR : NIT_FILL;
            end
            NIT_WR: begin
                ent_cnt_d = ent_cnt_q + 13'd1;
                state_d   = ent_cnt_d != ents_q ? NIT_FILL : FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            base_q     <= '0;
            lines_q    <= '0;
            ents_q     <= '0;
            line_cnt_q <= '0;
            ent_cnt_q  <= '0;
            bcnt_q     <= '0;
            gb_q       <= '0;
            nit_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            lines_q    <= lines_d;
            ents_q     <= ents_d;
            line_cnt_q <= line_cnt_d;
            ent_cnt_q  <= ent_cnt_d;
            bcnt_q     <= bcnt_d;
            gb_q       <= gb_d;
            nit_q      <= nit_d;
        end
    end

    assign s_ready          = state_q == GB_FILL || state_q == NIT_FILL;
    assign global_buf_write = state_q == GB_WR;
    assign NIT_write        = state_q == NIT_WR;
    assign waddr            = base_q + global_buf_addr_width'(line_cnt_q);
    assign NIT_addr         = ent_cnt_q[NIT_addr_width-1:0];
    assign GB_data_line     = gb_q;
    assign NIT_data         = nit_q;
    assign busy             = state_q != IDLE && state_q != FIN;
    assign LOAD_DONE        = state_q == FIN;
endmodule

// File: tb/tb_data_loader.sv
// tb_data_loader: random and directed loads checked against a queue of expected line/entry writes.
module tb_data_loader;
    logic         clk = 1'b0;
    logic         rstn, start, s_valid;
    logic [15:0]  INIT_LOAD_ADDR, GB_LINES;
    logic [12:0]  NIT_ENTRIES;
    logic [7:0]   s_data;
    logic         s_ready, global_buf_write, NIT_write, busy, LOAD_DONE;
    logic [15:0]  waddr;
    logic [127:0] GB_data_line;
    logic [11:0]  NIT_addr;
    logic [329:0] NIT_data;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_nit;
        logic [15:0]  addr;
        logic [329:0] data;
    } wr_t;

    data_loader dut (
        .clk(clk), .rstn(rstn), .start(start), .INIT_LOAD_ADDR(INIT_LOAD_ADDR),
        .GB_LINES(GB_LINES), .NIT_ENTRIES(NIT_ENTRIES), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .global_buf_write(global_buf_write), .waddr(waddr),
        .GB_data_line(GB_data_line), .NIT_write(NIT_write), .NIT_addr(NIT_addr),
        .NIT_data(NIT_data), .busy(busy), .LOAD_DONE(LOAD_DONE)
    );

    always #5 clk = ~clk;

    // mode: 0 back-to-back, 1 valid toggling, 2 random gaps; pat: 0 random, 1 sequential, 2 NIT pattern
    task automatic do_load(input string name, input logic [15:0] addr, input logic [15:0] lines,
                           input logic [12:0] ents, input int mode, input int pat, input bit poke);
        logic [7:0] bs[$];
        wr_t        exp_q[$];
        wr_t        w;
        logic [9:0] v;
        logic [1:0] exp_pair;
        int n_gb, total, k, cyc, p;
        bit done, exp_strobe;
        n_gb  = int'(lines) * 16;
        total = n_gb + int'(ents) * 66;
        for (int i = 0; i < total; i++) begin
            p = (i - n_gb) % 66;
            v = 10'(p / 2 + 'h3C0);
            if (i < n_gb) bs.push_back(pat == 1 ? 8'(i) : 8'($urandom));
            else if (pat == 2) bs.push_back(p % 2 == 0 ? v[7:0] : {6'h3F, v[9:8]});
            else bs.push_back(8'($urandom));
        end
        for (int l = 0; l < int'(lines); l++) begin
            w.is_nit = 0;
            w.addr = addr + 16'(l);
            w.data = '0;
            for (int j = 0; j < 16; j++) w.data[8*j +: 8] = bs[16*l + j];
            exp_q.push_back(w);
        end
        for (int e = 0; e < int'(ents); e++) begin
            w.is_nit = 1;
            w.addr = 16'(e % 4096);
            w.data = '0;
            for (int i = 0; i < 33; i++)
                w.data[10*i +: 10] = {bs[n_gb + 66*e + 2*i + 1][1:0], bs[n_gb + 66*e + 2*i]};
            exp_q.push_back(w);
        end
        @(negedge clk);
        INIT_LOAD_ADDR = addr; GB_LINES = lines; NIT_ENTRIES = ents; start = 1; s_valid = 0;
        @(negedge clk);
        start = 0;
        INIT_LOAD_ADDR = 16'($urandom); GB_LINES = 16'($urandom); NIT_ENTRIES = 13'($urandom);
        k = 0; cyc = 0; done = 0; exp_strobe = 0;
        while (!done && cyc < 6000) begin
            cyc++;
            exp_pair = exp_strobe ? (exp_q[0].is_nit ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if ({global_buf_write, NIT_write} !== exp_pair) begin
                errors++;
                $display("FAIL %s strobe cyc %0d: got gbw,nitw=%b exp %b", name, cyc, {global_buf_write, NIT_write}, exp_pair);
            end
            if (exp_strobe) begin
                w = exp_q.pop_front();
                checks++;
                if (!w.is_nit && (waddr !== w.addr || GB_data_line !== w.data[127:0])) begin
                    errors++;
                    $display("FAIL %s gb_write: got addr %h line %h exp addr %h line %h", name, waddr, GB_data_line, w.addr, w.data[127:0]);
                end
                if (w.is_nit && (NIT_addr !== w.addr[11:0] || NIT_data !== w.data)) begin
                    errors++;
                    $display("FAIL %s nit_write: got addr %h data %h exp addr %h data %h", name, NIT_addr, NIT_data, w.addr[11:0], w.data);
                end
            end
            exp_strobe = 0;
            checks++;
            if (s_ready === 1'b1 && k >= total) begin
                errors++;
                $display("FAIL %s s_ready: got 1 exp 0 after %0d bytes", name, k);
            end
            if (LOAD_DONE === 1'b1) begin
                done = 1;
                checks++;
                if (busy !== 1'b0 || exp_q.size() != 0 || k != total) begin
                    errors++;
                    $display("FAIL %s done: got busy %b pending %0d bytes %0d exp busy 0 pending 0 bytes %0d", name, busy, exp_q.size(), k, total);
                end
                if (mode == 0) begin
                    checks++;
                    if (cyc != int'(lines) * 17 + int'(ents) * 67 + 1) begin
                        errors++;
                        $display("FAIL %s done_latency: got %0d exp %0d", name, cyc, int'(lines) * 17 + int'(ents) * 67 + 1);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cyc %0d: got %b exp 1", name, cyc, busy);
                end
            end
            s_valid = done || k >= total ? 1'b0 : mode == 0 ? 1'b1 : mode == 1 ? cyc % 2 == 1 : $urandom % 3 != 0;
            s_data = s_valid ? bs[k] : 8'($urandom);
            if (s_valid && s_ready) begin
                k++;
                exp_strobe = k <= n_gb ? k % 16 == 0 : (k - n_gb) % 66 == 0;
            end
            start = poke && !done && $urandom % 5 == 0;
            @(negedge clk);
        end
        s_valid = 0; start = 0;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got no LOAD_DONE in %0d cycles exp done", name, cyc);
        end
    endtask

    task automatic test_reset();
        rstn = 1; start = 0; s_valid = 0; s_data = 0;
        INIT_LOAD_ADDR = 0; GB_LINES = 0; NIT_ENTRIES = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, global_buf_write, NIT_write, busy, LOAD_DONE, waddr, NIT_addr, GB_data_line, NIT_data} !== '0) begin
            errors++;
            $display("FAIL reset: got rdy %b gbw %b nitw %b busy %b done %b waddr %h exp all 0", s_ready, global_buf_write, NIT_write, busy, LOAD_DONE, waddr);
        end
        rstn = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        INIT_LOAD_ADDR = 16'h0200; GB_LINES = 1; NIT_ENTRIES = 0; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1; s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 0; rstn = 1;
        @(negedge clk);
        rstn = 0;
        checks++;
        if ({s_ready, global_buf_write, NIT_write, busy, LOAD_DONE, waddr, NIT_addr, GB_data_line, NIT_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rdy %b busy %b waddr %h line %h exp all 0", s_ready, busy, waddr, GB_data_line);
        end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({global_buf_write, NIT_write, LOAD_DONE, busy} !== 4'b0) begin
                errors++;
                $display("FAIL reset_idle: got gbw,nitw,done,busy=%b exp 0000", {global_buf_write, NIT_write, LOAD_DONE, busy});
            end
        end
        s_valid = 0;
        do_load("reset_reload", 16'h0200, 16'd1, 13'd0, 0, 0, 0);
    endtask

    task automatic test_gb_b2b();      do_load("gb_b2b", 16'h0100, 16'd2, 13'd0, 0, 1, 0); endtask
    task automatic test_nit_pattern(); do_load("nit_pattern", 16'h1234, 16'd0, 13'd1, 0, 2, 0); endtask
    task automatic test_empty();       do_load("empty", 16'($urandom), 16'd0, 13'd0, 0, 0, 0); endtask
    task automatic test_toggle();      do_load("toggle", 16'h0100, 16'd1, 13'd0, 1, 1, 0); endtask
    task automatic test_wrap();        do_load("wrap", 16'hFFFF, 16'd2, 13'd0, 0, 1, 1); endtask

    task automatic test_back_to_back();
        do_load("mixed_gaps", 16'($urandom), 16'd3, 13'd2, 2, 0, 1);
        do_load("mixed_b2b", 16'($urandom), 16'd2, 13'd2, 0, 0, 1);
        do_load("nit_toggle", 16'($urandom), 16'd0, 13'd2, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_gb_b2b();
        test_nit_pattern();
        test_empty();
        test_toggle();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
